// File: rtl/stream_packetizer.sv
// rtl/stream_packetizer.sv - frames words from a FWFT FIFO into header+payload packets
//
// Ports:
//   clk             - single clock, rising edge
//   rst_n           - asynchronous active-low reset
//   fifo_dout       - head word of the upstream first-word-fall-through FIFO
//   fifo_empty      - FIFO empty flag
//   fifo_data_count - FIFO occupancy
//   fifo_rd_en      - pop strobe, asserted in the same cycle as a payload transfer
//   m_data          - output stream data (header word or payload word)
//   m_valid         - output stream valid
//   m_ready         - output stream ready from the sink
//   m_last          - marks the final payload word of a packet
//   busy            - high while a packet is being emitted
//   pkt_count       - completed packets, wraps at 0xFFFF
//
// Header word layout: bits 23:16 sequence number, bits 15:0 payload length,
// all remaining upper bits zero.

module stream_packetizer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         fifo_dout,
    input  logic                     fifo_empty,
    input  logic [$clog2(DEPTH)-1:0] fifo_data_count,
    output logic                     fifo_rd_en,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic                     busy,
    output logic [15:0]              pkt_count
);

    // Timer only ever counts up to TIMEOUT-1 before a launch clears it.
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [15:0]   len;
    logic [15:0]   len_nxt;
    logic [15:0]   rem;
    logic [15:0]   rem_nxt;
    logic [7:0]    seq;
    logic          pkt_done;

    logic [31:0]   count_ext;
    logic          launch_full;
    logic          launch_timeout;

    assign count_ext      = 32'(fifo_data_count);
    assign launch_full    = (count_ext >= 32'(MAX_LEN));
    assign launch_timeout = !fifo_empty && (timer == TW'(TIMEOUT - 1));

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        len_nxt    = len;
        rem_nxt    = rem;
        pkt_done   = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_data     = '0;
        fifo_rd_en = 1'b0;

        case (state)
            IDLE: begin
                if (fifo_empty) begin
                    timer_nxt = '0;
                end else if (launch_full) begin
                    len_nxt   = 16'(MAX_LEN);
                    timer_nxt = '0;
                    state_nxt = HEADER;
                end else if (launch_timeout) begin
                    // Length is frozen here; later FIFO writes belong to the next packet.
                    len_nxt   = 16'(fifo_data_count);
                    timer_nxt = '0;
                    state_nxt = HEADER;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end

            HEADER: begin
                m_valid        = 1'b1;
                m_data[23:16]  = seq;
                m_data[15:0]   = len;
                if (m_ready) begin
                    rem_nxt   = len;
                    state_nxt = PAYLOAD;
                end
            end

            PAYLOAD: begin
                // FWFT head is presented directly; an empty FIFO simply stalls the packet.
                m_valid    = !fifo_empty;
                m_data     = fifo_dout;
                m_last     = (rem == 16'd1) && m_valid;
                fifo_rd_en = m_valid && m_ready;
                if (fifo_rd_en) begin
                    rem_nxt = rem - 16'd1;
                    if (m_last) begin
                        pkt_done  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            len       <= '0;
            rem       <= '0;
            seq       <= '0;
            pkt_count <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            len   <= len_nxt;
            rem   <= rem_nxt;
            if (pkt_done) begin
                seq       <= seq + 8'd1;
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_stream_packetizer.sv
// tb/tb_stream_packetizer.sv - self-checking bench for stream_packetizer

module tb_stream_packetizer;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 16;
    localparam int MAX_LEN = 4;
    localparam int TIMEOUT = 8;
    localparam int CW      = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_data_count;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic             busy;
    logic [15:0]      pkt_count;

    always #5 clk = ~clk;

    stream_packetizer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_data_count(fifo_data_count), .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .pkt_count(pkt_count)
    );

    // FWFT FIFO model
    logic [WIDTH-1:0] mem [0:255];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    int               pops = 0;
    logic             pop_req = 1'b0;
    logic             cnt_ovr_en = 1'b0;
    logic [CW-1:0]    cnt_ovr = '0;

    assign fifo_empty      = (rd_ptr == wr_ptr);
    assign fifo_dout       = fifo_empty ? '0 : mem[rd_ptr[7:0]];
    assign fifo_data_count = cnt_ovr_en ? cnt_ovr : CW'(wr_ptr - rd_ptr);

    always @(posedge clk) begin
        if (pop_req) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Output monitor and per-cycle protocol checks
    logic [WIDTH-1:0] log_data [$];
    logic             log_last [$];
    int               log_cyc [$];
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic             prev_last = 1'b0;

    always @(negedge clk) begin
        pop_req = fifo_rd_en;
        if (rst_n) begin
            if (m_valid && m_ready) begin
                log_data.push_back(m_data);
                log_last.push_back(m_last);
                log_cyc.push_back(cyc);
            end
            if (fifo_rd_en)
                chk("pop_needs_xfer", {61'd0, m_valid, m_ready, m_data == fifo_dout}, 64'd7);
            if (!busy)
                chk("idle_outputs", {61'd0, m_valid, m_last, fifo_rd_en}, 64'd0);
            if (prev_stall)
                chk("stall_hold", {30'd0, m_valid, m_last, m_data}, {30'd0, 1'b1, prev_last, prev_data});
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push(input logic [WIDTH-1:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        m_ready    = 1'b1;
        cnt_ovr_en = 1'b0;
        clear_log();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int k = 0;
        while (log_data.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk($sformatf("%s_wait", name), 64'(log_data.size() >= n), 64'd1);
    endtask

    // Walks the log against expected headers; payload words are base, base+1, ...
    logic [31:0] exp_hdr [$];

    task automatic verify(input logic [31:0] base, input string tag);
        int idx = 0;
        int w = 0;
        int len;
        foreach (exp_hdr[h]) begin
            if (idx >= log_data.size()) begin
                chk($sformatf("%s_short", tag), 64'(log_data.size()), 64'(idx + 1));
                return;
            end
            chk($sformatf("%s_hdr%0d", tag, h), log_data[idx], exp_hdr[h]);
            chk($sformatf("%s_hdr%0d_last", tag, h), log_last[idx], 0);
            idx++;
            len = int'(exp_hdr[h][15:0]);
            for (int k = 0; k < len; k++) begin
                if (idx >= log_data.size()) begin
                    chk($sformatf("%s_short", tag), 64'(log_data.size()), 64'(idx + 1));
                    return;
                end
                chk($sformatf("%s_p%0d_%0d", tag, h, k), log_data[idx], base + 32'(w));
                chk($sformatf("%s_p%0d_%0d_last", tag, h, k), log_last[idx], 64'(k == len - 1));
                idx++;
                w++;
            end
        end
        chk($sformatf("%s_count", tag), 64'(log_data.size()), 64'(idx));
    endtask

    typedef struct {
        int          nwords;
        int          lat;
        int          nhdr;
        logic [31:0] h0;
        logic [31:0] h1;
        logic [31:0] h2;
    } vec_t;

    vec_t vecs [6];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] base;
        int          p0;
        int          c0;
        int          k;

        vecs[0] = '{nwords: 4,  lat: 1, nhdr: 1, h0: 32'h0000_0004, h1: 32'h0, h2: 32'h0};
        vecs[1] = '{nwords: 2,  lat: 8, nhdr: 1, h0: 32'h0000_0002, h1: 32'h0, h2: 32'h0};
        vecs[2] = '{nwords: 10, lat: 1, nhdr: 3, h0: 32'h0000_0004, h1: 32'h0001_0004, h2: 32'h0002_0002};
        vecs[3] = '{nwords: 1,  lat: 8, nhdr: 1, h0: 32'h0000_0001, h1: 32'h0, h2: 32'h0};
        vecs[4] = '{nwords: 5,  lat: 1, nhdr: 2, h0: 32'h0000_0004, h1: 32'h0001_0001, h2: 32'h0};
        vecs[5] = '{nwords: 3,  lat: 8, nhdr: 1, h0: 32'h0000_0003, h1: 32'h0, h2: 32'h0};

        // Asynchronous reset, checked before any clock edge
        m_ready = 1'b1;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {12'd0, m_valid, m_last, fifo_rd_en, busy, pkt_count, m_data},
            64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table-driven packets
        for (int v = 0; v < 6; v++) begin
            do_reset();
            exp_hdr.delete();
            exp_hdr.push_back(vecs[v].h0);
            if (vecs[v].nhdr > 1) exp_hdr.push_back(vecs[v].h1);
            if (vecs[v].nhdr > 2) exp_hdr.push_back(vecs[v].h2);
            base = 32'hA000_0000 + 32'(v << 8);
            p0 = pops;
            c0 = cyc;
            for (int i = 0; i < vecs[v].nwords; i++) push(base + 32'(i));
            wait_log(vecs[v].nhdr + vecs[v].nwords, 200, $sformatf("vec%0d", v));
            if (log_cyc.size() > 0)
                chk($sformatf("vec%0d_latency", v), 64'(log_cyc[0] - c0), 64'(vecs[v].lat));
            verify(base, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_pkt_count", v), pkt_count, 64'(vecs[v].nhdr));
            chk($sformatf("vec%0d_fifo_empty", v), fifo_empty, 1);
            chk($sformatf("vec%0d_pops", v), 64'(pops - p0), 64'(vecs[v].nwords));
        end

        // Backpressure in mid-payload
        do_reset();
        exp_hdr.delete();
        exp_hdr.push_back(32'h0000_0004);
        base = 32'hB000_0000;
        p0 = pops;
        for (int i = 0; i < 4; i++) push(base + 32'(i));
        wait_log(2, 50, "bp_head");
        m_ready = 1'b0;
        #1;
        chk("bp_rd_en_0", fifo_rd_en, 0);
        chk("bp_data_0", m_data, base + 32'd1);
        @(posedge clk);
        #1;
        chk("bp_rd_en_1", fifo_rd_en, 0);
        chk("bp_data_1", m_data, base + 32'd1);
        chk("bp_pops_held", 64'(pops - p0), 64'd1);
        m_ready = 1'b1;
        wait_log(5, 50, "bp_tail");
        verify(base, "bp");
        chk("bp_pops", 64'(pops - p0), 64'd4);

        // FIFO runs dry in mid-payload: occupancy is overstated so len exceeds what is present
        do_reset();
        exp_hdr.delete();
        exp_hdr.push_back(32'h0000_0004);
        base = 32'hD000_0000;
        p0 = pops;
        cnt_ovr    = CW'(4);
        cnt_ovr_en = 1'b1;
        push(base);
        push(base + 32'd1);
        k = 0;
        while (!busy && k < 20) begin @(posedge clk); #1; k++; end
        cnt_ovr_en = 1'b0;
        wait_log(3, 50, "dry_head");
        repeat (3) @(posedge clk);
        #1;
        chk("dry_stall", {61'd0, m_valid, fifo_rd_en, busy}, 64'd1);
        push(base + 32'd2);
        push(base + 32'd3);
        wait_log(5, 50, "dry_tail");
        verify(base, "dry");
        chk("dry_pkt_count", pkt_count, 1);
        chk("dry_pops", 64'(pops - p0), 64'd4);

        // Words written after a timeout launch stay out of that packet
        do_reset();
        exp_hdr.delete();
        exp_hdr.push_back(32'h0000_0002);
        exp_hdr.push_back(32'h0001_0003);
        base = 32'hC000_0000;
        push(base);
        push(base + 32'd1);
        k = 0;
        while (!busy && k < 40) begin @(posedge clk); #1; k++; end
        chk("late_busy", busy, 1);
        for (int i = 2; i < 5; i++) push(base + 32'(i));
        wait_log(7, 100, "late");
        verify(base, "late");
        chk("late_pkt_count", pkt_count, 2);

        // Reset in mid-packet abandons it; leftover words form the next packet
        do_reset();
        base = 32'hE000_0000;
        for (int i = 0; i < 4; i++) push(base + 32'(i));
        wait_log(5, 50, "mid_first");
        chk("mid_first_pkt", pkt_count, 1);
        clear_log();
        base = 32'hF000_0000;
        for (int i = 0; i < 4; i++) push(base + 32'(i));
        wait_log(3, 50, "mid_two");
        chk("mid_hdr_seq1", log_data[0], 32'h0001_0004);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs",
            {12'd0, m_valid, m_last, fifo_rd_en, busy, pkt_count, m_data}, 64'd0);
        clear_log();
        repeat (2) @(posedge clk);
        #1;
        chk("mid_fifo_left", 64'(wr_ptr - rd_ptr), 64'd2);
        rst_n = 1'b1;
        exp_hdr.delete();
        exp_hdr.push_back(32'h0000_0002);
        wait_log(3, 100, "mid_after");
        verify(base + 32'd2, "mid_after");
        chk("mid_after_pkt", pkt_count, 1);

        // Sequence number wrap over 257 one-word packets
        do_reset();
        base = 32'h1234_0000;
        for (int i = 0; i < 257; i++) begin
            push(base + 32'(i));
            wait_log(2 * i + 2, 40, $sformatf("wrap%0d", i));
            chk($sformatf("wrap%0d_hdr", i), log_data[2 * i], {8'd0, 8'(i), 16'd1});
            chk($sformatf("wrap%0d_data", i), {log_last[2 * i + 1], log_data[2 * i + 1]},
                {1'b1, base + 32'(i)});
            if (i == 255) begin
                chk("wrap_seq_ff", log_data[2 * i][23:16], 8'hFF);
                chk("wrap_pkt_256", pkt_count, 16'd256);
            end
            if (i == 256) chk("wrap_seq_00", log_data[2 * i][23:16], 8'h00);
        end
        chk("wrap_pkt_257", pkt_count, 16'd257);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
